// File: rtl/chardisp_axi_pkg.sv
// Shared constants and helpers for the character display AXI4-Lite register bank.
package chardisp_axi_pkg;

    localparam int NUM_REGS = 4;
    localparam int IDX_W    = 2;

    typedef logic [IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_CTRL  = 2'd0;
    localparam reg_idx_t REG_CHAR  = 2'd1;
    localparam reg_idx_t REG_POS   = 2'd2;
    localparam reg_idx_t REG_COLOR = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx);
        idx_onehot      = '0;
        idx_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/chardisp_axi_reg_bank.sv
// Register storage with byte-strobe merge, per-register write pulse and read mux.
// Latency: write visible and pulse high the cycle after wr_en; read mux is combinational.
// Backpressure: none, every wr_en is committed.
module chardisp_axi_reg_bank
    import chardisp_axi_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  reg_idx_t               wr_idx,
    input  logic [DW-1:0]          wr_dat,
    input  logic [DW/8-1:0]        wr_strb,
    input  reg_idx_t               rd_idx,
    output logic [DW-1:0]          rd_dat,
    output logic [NUM_REGS*DW-1:0] reg_q,
    output logic [NUM_REGS-1:0]    wr_pulse
);

    logic [DW-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_pulse <= '0;
        end else begin
            // The pulse fires on every committed write, even with an all-zero strobe.
            wr_pulse <= wr_en ? idx_onehot(wr_idx) : '0;
            if (wr_en) begin
                for (int b = 0; b < DW/8; b++) begin
                    if (wr_strb[b]) begin
                        regs[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
                    end
                end
            end
        end
    end

    assign rd_dat = regs[rd_idx];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DW +: DW] = regs[g];
    end

endmodule

// File: rtl/chardisp_axi_lite_slave.sv
// AXI4-Lite slave: one-entry AW and W buffers, single outstanding write and read.
// Latency: commit/bvalid one cycle after the later of AW/W; rvalid one cycle after AR.
// Backpressure: AW/W stall while a buffer is full or bvalid is pending; AR stalls while rvalid.
module chardisp_axi_lite_slave
    import chardisp_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]               reg_wr_pulse
);

    localparam int DW = C_S_AXI_DATA_WIDTH;

    logic            rdy_en;
    logic            aw_full, w_full;
    reg_idx_t        aw_idx;
    logic [DW-1:0]   w_dat;
    logic [DW/8-1:0] w_strb;
    logic            aw_hs, w_hs, ar_hs, commit;
    reg_idx_t        cm_idx;
    logic [DW-1:0]   cm_dat, rd_dat;
    logic [DW/8-1:0] cm_strb;
    logic            unused_ok;

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Holds the ready outputs low until the first edge after reset release.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) rdy_en <= 1'b0;
        else                  rdy_en <= 1'b1;
    end

    assign s00_axi_awready = rdy_en && !aw_full && !s00_axi_bvalid;
    assign s00_axi_wready  = rdy_en && !w_full  && !s00_axi_bvalid;
    assign s00_axi_arready = rdy_en && !s00_axi_rvalid;
    assign s00_axi_bresp   = AXI_RESP_OKAY;
    assign s00_axi_rresp   = AXI_RESP_OKAY;

    assign aw_hs  = s00_axi_awvalid && s00_axi_awready;
    assign w_hs   = s00_axi_wvalid  && s00_axi_wready;
    assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
    assign commit = (aw_full || aw_hs) && (w_full || w_hs);

    assign cm_idx  = aw_full ? aw_idx : s00_axi_awaddr[3:2];
    assign cm_dat  = w_full  ? w_dat  : s00_axi_wdata;
    assign cm_strb = w_full  ? w_strb : s00_axi_wstrb;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_full        <= 1'b0;
            w_full         <= 1'b0;
            aw_idx         <= '0;
            w_dat          <= '0;
            w_strb         <= '0;
            s00_axi_bvalid <= 1'b0;
        end else begin
            if (commit) begin
                aw_full        <= 1'b0;
                w_full         <= 1'b0;
                s00_axi_bvalid <= 1'b1;
            end else begin
                if (aw_hs) begin
                    aw_full <= 1'b1;
                    aw_idx  <= s00_axi_awaddr[3:2];
                end
                if (w_hs) begin
                    w_full <= 1'b1;
                    w_dat  <= s00_axi_wdata;
                    w_strb <= s00_axi_wstrb;
                end
                if (s00_axi_bvalid && s00_axi_bready) s00_axi_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_rvalid <= 1'b0;
            s00_axi_rdata  <= '0;
        end else if (ar_hs) begin
            s00_axi_rvalid <= 1'b1;
            s00_axi_rdata  <= rd_dat;
        end else if (s00_axi_rvalid && s00_axi_rready) begin
            s00_axi_rvalid <= 1'b0;
        end
    end

    chardisp_axi_reg_bank #(.DW(DW)) u_reg_bank (
        .clk      (s00_axi_aclk),
        .rst_n    (s00_axi_aresetn),
        .wr_en    (commit),
        .wr_idx   (cm_idx),
        .wr_dat   (cm_dat),
        .wr_strb  (cm_strb),
        .rd_idx   (s00_axi_araddr[3:2]),
        .rd_dat   (rd_dat),
        .reg_q    (reg_q),
        .wr_pulse (reg_wr_pulse)
    );

endmodule

// File: doc/chardisp_axi_lite_slave.md
# chardisp_axi_lite_slave

AXI4-Lite slave register bank for the character display IP. It is the responder end of the S00_AXI interface that the block-design master drives. It holds four 32-bit read/write registers, applies byte strobes, and returns OKAY responses. It presents the register contents and one-cycle write pulses to the display core.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 4, byte address width; 4 registers × 4 bytes

Ports:
- s00_axi_aclk  in  1  sole clock, all logic on rising edge
- s00_axi_aresetn  in  1  asynchronous active-low reset
- s00_axi_awaddr  in  4  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid / s00_axi_awready  in / out  1  AW handshake
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte enables
- s00_axi_wvalid / s00_axi_wready  in / out  1  W handshake
- s00_axi_bresp  out  2  always 2'b00
- s00_axi_bvalid / s00_axi_bready  out / in  1  B handshake
- s00_axi_araddr  in  4  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  always 2'b00
- s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake
- reg_q  out  128  {reg3, reg2, reg1, reg0} current contents
- reg_wr_pulse  out  4  one-cycle pulse per register on each committed write

## Operation
- Register index = addr[3:2]. addr[1:0] is ignored, so unaligned addresses hit the containing word.
- Write path holds two independent one-entry buffers: AW (index) and W (data, strobe).
  - awready = !aw_full && !bvalid; wready = !w_full && !bvalid.
  - AW and W may arrive in either order, or in the same cycle.
- Commit happens on the edge where both AW and W are present, whether buffered or handshaking that cycle. On commit:
  - For each byte b with wstrb[b]=1, reg[idx][8b+7:8b] <= wdata byte b; other bytes are kept.
  - reg_wr_pulse[idx] is high for exactly the following cycle, even when wstrb = 0.
  - Both buffers are cleared and bvalid is set.
- bvalid is held until bready is sampled high. The next AW/W is not accepted while bvalid is high, so at most one write is outstanding.
- Read path: arready = !rvalid. On an AR handshake, rdata <= reg[araddr[3:2]] and rvalid <= 1.
  - rdata stays stable until the R handshake; rvalid clears on that edge.
- Read and write paths are independent. A read sampled on the same edge as a write commit to the same register returns the old value.
- awprot and arprot have no effect. No error responses are ever generated.

## Timing
- Write latency: last of AW/W handshakes in cycle N → bvalid high and reg_q updated in cycle N+1; reg_wr_pulse high in N+1 only.
- Earliest next write acceptance is the cycle after the B handshake.
- Read latency: AR handshake in cycle N → rvalid/rdata valid in N+1. Back-to-back reads run every 2 cycles with rready tied high.
- During and after reset:
  - awready, wready, arready = 0 while aresetn is low, and 1 in the first cycle after release.
  - bvalid, rvalid, rdata, bresp, rresp, reg_q, reg_wr_pulse = 0.
- Reset asserted mid-transaction discards buffered AW/W and any pending B/R. The master must restart the transaction.

## Structure
- Package chardisp_axi_pkg:
  - register index constants REG_CTRL=0, REG_CHAR=1, REG_POS=2, REG_COLOR=3
  - AXI_RESP_OKAY=2'b00
  - NUM_REGS=4
- Sub-module chardisp_axi_reg_bank: storage, strobe merge, write-pulse generation and the read mux.
- Top chardisp_axi_lite_slave: handshake buffers and B/R valid logic.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then read back all four → rdata 0x1..0x4, all responses OKAY, reg_q = 0x00000004_00000003_00000002_00000001.
- W (0xDEADBEEF, strobe 0xF) issued 3 cycles before AW (addr 0x8) → wready drops after the W handshake; commit on the AW edge; reg2 = 0xDEADBEEF; reg_wr_pulse = 4'b0100 for exactly one cycle.
- reg0 = 0x00000001, then write 0xAABBCCDD with wstrb 4'b0010 to addr 0x2 → reg0 = 0x0000CC01.
- bready held low 5 cycles after a write → bvalid stays high, awready and wready stay 0, and a second write is only accepted after the B handshake.
- Read addr 0x4 with rready low 4 cycles → rvalid and rdata are stable throughout and arready is 0. A write to reg1 committing on the AR edge leaves the old value in rdata.
- aresetn pulsed low with AW accepted but W not yet accepted → no commit, all registers 0, bvalid 0. A fresh write after release completes normally.
